instr_mem_sync: RTL and testbench

Parametrised, synchronous-read instruction memory for the pipelined RV32I core, replacing the combinational 1 KB ROM. It holds byte-addressed little-endian words and returns one instruction per fetch with one-cycle latency. The front-end can stall or flush it. A loader port (byte-enabled word writes) lets a testbench or boot loader rewrite the program at run time. An optional post-reset scrub fills memory with NOPs.

---
 rtl/instr_mem_sync.sv | 156 +++++++++++++++
 tb/tb_instr_mem_sync.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_sync.sv
// instr_mem_sync: synchronous-read instruction memory with a one-cycle fetch
// latency, a byte-enabled loader port and an optional post-reset NOP scrub.
module instr_mem_sync #(
  parameter int unsigned DEPTH_WORDS    = 256,
  parameter int unsigned ADDR_W         = 12,
  parameter string       INIT_FILE      = "",
  parameter bit          CLEAR_ON_RESET = 1'b0,
  parameter logic [31:0] NOP_WORD       = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              stall,
  input  logic              flush,
  output logic [31:0]       instr,
  output logic              instr_valid,
  output logic              instr_fault,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [3:0]        ld_be,
  output logic              busy
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_RUN,
    S_CLEAR,
    S_LOAD
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [IDX_W-1:0] w_f_idx;
  logic [IDX_W-1:0] w_ld_idx;
  logic             w_f_oor;
  logic             w_ld_oor;
  logic             w_f_fault;
  logic             w_accept;
  logic             w_mem_we;
  logic [IDX_W-1:0] w_wr_idx;
  logic [3:0]       w_wr_be;
  logic [31:0]      w_wr_data;
  logic             w_unused_ld_lsb;

  assign w_f_idx         = fetch_addr[IDX_W+1:2];
  assign w_ld_idx        = ld_addr[IDX_W+1:2];
  assign w_f_fault       = (fetch_addr[1:0] != 2'b00) || w_f_oor;
  assign w_unused_ld_lsb = ^ld_addr[1:0];

  // Any set address bit above the array index means the word is out of range;
  // such accesses fault (fetch) or are dropped (load) instead of aliasing.
  generate
    if (ADDR_W > IDX_W + 2) begin : g_hi_bits
      assign w_f_oor  = |fetch_addr[ADDR_W-1:IDX_W+2];
      assign w_ld_oor = |ld_addr[ADDR_W-1:IDX_W+2];
    end else begin : g_no_hi_bits
      assign w_f_oor  = 1'b0;
      assign w_ld_oor = 1'b0;
    end
  endgenerate

  // Power-up contents: NOP everywhere.
  initial begin
    for (int unsigned i = 0; i < DEPTH_WORDS; i++) r_mem[i] = NOP_WORD;
  end

  // State register; reset selects scrub or straight to service.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
    else      r_state <= w_state_nxt;
  end

  // Scrub word counter, restarts from word 0 on every reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    r_cnt <= '0;
    else if (r_state == S_CLEAR) r_cnt <= r_cnt + IDX_W'(1);
  end

  // Next-state: scrub runs to the last word, loader owns the array while ld_we.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (r_cnt == IDX_W'(DEPTH_WORDS - 1)) w_state_nxt = S_RUN;
      S_RUN:   if (ld_we)  w_state_nxt = S_LOAD;
      S_LOAD:  if (!ld_we) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State decode: busy flag, fetch acceptance and array write port selection.
  always_comb begin
    busy      = 1'b0;
    w_accept  = 1'b0;
    w_mem_we  = 1'b0;
    w_wr_idx  = w_ld_idx;
    w_wr_be   = ld_be;
    w_wr_data = ld_data;
    case (r_state)
      S_CLEAR: begin
        busy      = 1'b1;
        w_mem_we  = 1'b1;
        w_wr_idx  = r_cnt;
        w_wr_be   = '1;
        w_wr_data = NOP_WORD;
      end
      S_LOAD: begin
        busy     = 1'b1;
        w_mem_we = ld_we && !w_ld_oor;
      end
      S_RUN: begin
        // A loader write entering LOAD takes this edge; any fetch is dropped.
        w_mem_we = ld_we && !w_ld_oor;
        w_accept = !ld_we && fetch_req && !stall && !flush;
      end
      default: ;
    endcase
  end

  // Array write port with per-byte enables; unselected bytes keep their value.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_wr_be[b]) r_mem[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
      end
    end
  end

  // Fetch output register: flush > stall > accepted fetch > idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
    end else if (flush) begin
      instr       <= NOP_WORD;
      instr_valid <= 1'b0;
      instr_fault <= 1'b0;
    end else if (!stall) begin
      if (w_accept) begin
        instr       <= w_f_fault ? NOP_WORD : r_mem[w_f_idx];
        instr_valid <= 1'b1;
        instr_fault <= w_f_fault;
      end else begin
        instr_valid <= 1'b0;
        instr_fault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Scoreboard bench for instr_mem_sync: one instance scrubs on reset, the other
// keeps its contents across reset.
module tb_instr_mem_sync;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic        fault;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_scrub;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  logic        a_rst, a_freq, a_stall, a_flush, a_ldwe, a_valid, a_fault, a_busy;
  logic [11:0] a_faddr, a_ldaddr;
  logic [31:0] a_lddata, a_instr;
  logic [3:0]  a_ldbe;

  logic        b_rst, b_freq, b_stall, b_flush, b_ldwe, b_valid, b_fault, b_busy;
  logic [11:0] b_faddr, b_ldaddr;
  logic [31:0] b_lddata, b_instr;
  logic [3:0]  b_ldbe;

  instr_mem_sync #(.DEPTH_WORDS(256), .ADDR_W(12), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rst(a_rst), .fetch_req(a_freq), .fetch_addr(a_faddr),
    .stall(a_stall), .flush(a_flush), .instr(a_instr), .instr_valid(a_valid),
    .instr_fault(a_fault), .ld_we(a_ldwe), .ld_addr(a_ldaddr), .ld_data(a_lddata),
    .ld_be(a_ldbe), .busy(a_busy)
  );

  instr_mem_sync #(.DEPTH_WORDS(256), .ADDR_W(12), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .rst(b_rst), .fetch_req(b_freq), .fetch_addr(b_faddr),
    .stall(b_stall), .flush(b_flush), .instr(b_instr), .instr_valid(b_valid),
    .instr_fault(b_fault), .ld_we(b_ldwe), .ld_addr(b_ldaddr), .ld_data(b_lddata),
    .ld_be(b_ldbe), .busy(b_busy)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitors: every valid output pops the oldest expectation.
  always @(negedge clk) begin
    if (a_valid === 1'b1) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_a: got instr=%h fault=%b expected no output", a_instr, a_fault);
      end else begin
        ea = qa.pop_front();
        chk("fetch_a", {a_fault, a_instr}, {ea.fault, ea.instr});
      end
    end
  end

  always @(negedge clk) begin
    if (b_valid === 1'b1) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_b: got instr=%h fault=%b expected no output", b_instr, b_fault);
      end else begin
        eb = qb.pop_front();
        chk("fetch_b", {b_fault, b_instr}, {eb.fault, eb.instr});
      end
    end
  end

  task automatic a_fetch(input logic [11:0] addr, input logic [31:0] ei, input logic ef);
    a_freq = 1'b1; a_faddr = addr; qa.push_back({ef, ei});
    @(negedge clk);
  endtask

  task automatic b_fetch(input logic [11:0] addr, input logic [31:0] ei, input logic ef);
    b_freq = 1'b1; b_faddr = addr; qb.push_back({ef, ei});
    @(negedge clk);
  endtask

  task automatic a_idle();
    a_freq = 1'b0;
    @(negedge clk);
  endtask

  task automatic a_load(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] be);
    a_ldwe = 1'b1; a_ldaddr = addr; a_lddata = d; a_ldbe = be;
    @(negedge clk);
  endtask

  task automatic b_load(input logic [11:0] addr, input logic [31:0] d, input logic [3:0] be);
    b_ldwe = 1'b1; b_ldaddr = addr; b_lddata = d; b_ldbe = be;
    @(negedge clk);
  endtask

  task automatic count_scrub(output int n);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (a_busy !== 1'b1) break;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst = 1'b0; a_freq = 1'b0; a_stall = 1'b0; a_flush = 1'b0; a_ldwe = 1'b0;
    a_faddr = '0; a_ldaddr = '0; a_lddata = '0; a_ldbe = '0;
    b_rst = 1'b0; b_freq = 1'b0; b_stall = 1'b0; b_flush = 1'b0; b_ldwe = 1'b0;
    b_faddr = '0; b_ldaddr = '0; b_lddata = '0; b_ldbe = '0;
    repeat (3) @(negedge clk);

    chk("rst_a_instr", a_instr, NOP);
    chk("rst_a_valid", a_valid, 1'b0);
    chk("rst_a_fault", a_fault, 1'b0);
    chk("rst_a_busy",  a_busy,  1'b1);
    chk("rst_b_busy",  b_busy,  1'b0);
    chk("rst_b_instr", b_instr, NOP);

    // Scrub: fetch requests held high must be ignored while busy.
    a_rst = 1'b1; b_rst = 1'b1; a_freq = 1'b1; a_faddr = 12'h000;
    count_scrub(n_scrub);
    a_freq = 1'b0;
    chk("scrub_cycles", n_scrub, 256);
    a_fetch(12'h000, NOP, 1'b0);
    a_fetch(12'h3FC, NOP, 1'b0);
    a_idle();

    // Loader burst, including a partial write and an out-of-range write.
    a_load(12'h010, 32'h000C8093, 4'hF);
    chk("busy_in_load", a_busy, 1'b1);
    a_load(12'h010, 32'h0000AA00, 4'b0010);
    a_load(12'h000, 32'h00100093, 4'hF);
    a_load(12'h004, 32'h00200113, 4'hF);
    a_load(12'h008, 32'h00308193, 4'hF);
    a_load(12'h400, 32'hDEADBEEF, 4'hF);
    a_ldwe = 1'b0; a_freq = 1'b1; a_faddr = 12'h010;
    @(negedge clk);
    chk("busy_after_load", a_busy, 1'b0);
    a_fetch(12'h010, 32'h000CAA93, 1'b0);
    a_idle();
    chk("idle_valid_drop", a_valid, 1'b0);
    chk("idle_instr_hold", a_instr, 32'h000CAA93);

    // Back-to-back fetches with a two-cycle stall on the second result.
    a_fetch(12'h000, 32'h00100093, 1'b0);
    a_fetch(12'h004, 32'h00200113, 1'b0);
    a_stall = 1'b1; a_freq = 1'b1; a_faddr = 12'h008;
    qa.push_back({1'b0, 32'h00200113});
    @(negedge clk);
    chk("stall_valid", a_valid, 1'b1);
    chk("stall_instr", a_instr, 32'h00200113);
    qa.push_back({1'b0, 32'h00200113});
    @(negedge clk);
    a_stall = 1'b0;
    a_fetch(12'h008, 32'h00308193, 1'b0);
    a_idle();

    // Faults: misaligned, beyond the array, both; then a clean last word.
    a_fetch(12'h006, NOP, 1'b1);
    a_fetch(12'h400, NOP, 1'b1);
    a_fetch(12'h008, 32'h00308193, 1'b0);
    a_fetch(12'hFFF, NOP, 1'b1);
    a_fetch(12'h3FC, NOP, 1'b0);
    a_idle();

    // Flush beats stall and a pending request.
    a_fetch(12'h004, 32'h00200113, 1'b0);
    a_flush = 1'b1; a_stall = 1'b1; a_freq = 1'b1; a_faddr = 12'h000;
    @(negedge clk);
    chk("flush_valid", a_valid, 1'b0);
    chk("flush_instr", a_instr, NOP);
    chk("flush_fault", a_fault, 1'b0);
    a_flush = 1'b0; a_stall = 1'b0; a_freq = 1'b0;
    @(negedge clk);
    chk("flush_no_accept", a_valid, 1'b0);

    // Asynchronous reset with a result on the outputs, then reset mid-scrub.
    a_fetch(12'h008, 32'h00308193, 1'b0);
    a_freq = 1'b0;
    #2 a_rst = 1'b0;
    #1;
    chk("async_rst_valid", a_valid, 1'b0);
    chk("async_rst_instr", a_instr, NOP);
    chk("async_rst_busy",  a_busy,  1'b1);
    @(negedge clk);
    a_rst = 1'b1;
    repeat (100) @(negedge clk);
    #2 a_rst = 1'b0;
    #1;
    chk("midscrub_rst_busy", a_busy, 1'b1);
    @(negedge clk);
    a_rst = 1'b1;
    count_scrub(n_scrub);
    chk("rescrub_cycles", n_scrub, 256);
    a_fetch(12'h010, NOP, 1'b0);
    a_idle();

    // Instance without scrub: contents survive a reset taken mid-LOAD.
    b_load(12'h020, 32'hCAFEF00D, 4'hF);
    b_load(12'h024, 32'h12000000, 4'b1000);
    b_ldwe = 1'b0;
    @(negedge clk);
    b_fetch(12'h020, 32'hCAFEF00D, 1'b0);
    b_freq = 1'b0; b_stall = 1'b1;
    b_ldwe = 1'b1; b_ldaddr = 12'h028; b_lddata = 32'hA5A5A5A5; b_ldbe = 4'hF;
    qb.push_back({1'b0, 32'hCAFEF00D});
    @(negedge clk);
    chk("b_load_busy",  b_busy,  1'b1);
    chk("b_load_hold",  b_valid, 1'b1);
    b_ldwe = 1'b0;
    #2 b_rst = 1'b0;
    #1;
    chk("b_rst_valid", b_valid, 1'b0);
    chk("b_rst_instr", b_instr, NOP);
    chk("b_rst_busy",  b_busy,  1'b0);
    b_stall = 1'b0;
    @(negedge clk);
    b_rst = 1'b1;
    b_fetch(12'h024, 32'h12000013, 1'b0);
    b_fetch(12'h028, 32'hA5A5A5A5, 1'b0);
    b_fetch(12'h020, 32'hCAFEF00D, 1'b0);
    b_freq = 1'b0;

    repeat (3) @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
